ddr3_cmd_arbiter: RTL and testbench

Round-robin command arbiter that shares the single DDR3 command/data/return FIFO set between up to NREQ requesters. It sits upstream of the DDR3 processing logic: it pushes granted 34-bit commands into the CMD FIFO and pushes single-cycle-write (SCW) bursts into the DATA FIFO. It also routes each single-cycle-read (SCR) result popped from the RETURN FIFO back to the requester that issued it, using an in-order tag queue.

---
 rtl/ddr3_arb_pkg.sv | 17 +
 rtl/ddr3_tag_fifo.sv | 51 +++++
 rtl/ddr3_cmd_arbiter.sv | 163 ++++++++++++++++
 tb/tb_ddr3_cmd_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_arb_pkg.sv
// Shared constants and types for the DDR3 command arbiter: opcode values,
// command field positions and the grant FSM encoding.
package ddr3_arb_pkg;
  localparam int CMD_W   = 34;
  localparam int WD_W    = 16;
  localparam int RET_W   = 42;

  localparam int OPC_HI  = 33;
  localparam int OPC_LO  = 31;
  localparam int ADDR_HI = 30;
  localparam int ADDR_LO = 5;

  localparam logic [2:0] SCR = 3'b001;
  localparam logic [2:0] SCW = 3'b010;

  typedef enum logic [1:0] {IDLE, WDATA, PUSH} arb_state_e;
endpackage

// File: rtl/ddr3_tag_fifo.sv
// Outstanding-read tag queue: holds the requester index of every SCR pushed
// to the CMD FIFO, in issue order, so returns can be routed back.
module ddr3_tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rptr_q];

  // A pop frees the head slot, so a push alongside it is accepted even when full.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wptr_d  = wptr_q + AW'(do_push);
    rptr_d  = rptr_q + AW'(do_pop);
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end
endmodule

// File: rtl/ddr3_cmd_arbiter.sv
// Round-robin arbiter sharing the DDR3 CMD/DATA/RETURN FIFOs between NREQ
// requesters; routes read returns back through an in-order tag queue.
module ddr3_cmd_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int BL        = 8,
  parameter int TAG_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*CMD_W-1:0] req_cmd,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WD_W-1:0]  req_wdata,
  output logic [NREQ-1:0]       req_wdata_get,
  input  logic                  CMD_full,
  output logic                  CMD_put,
  output logic [CMD_W-1:0]      CMD_data_in,
  input  logic                  DATA_full,
  output logic                  DATA_put,
  output logic [WD_W-1:0]       DATA_data_in,
  input  logic                  RETURN_empty,
  output logic                  RETURN_get,
  input  logic [RET_W-1:0]      RETURN_data_out,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [RET_W-1:0]      rsp_data,
  output logic                  err
);
  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(BL) + 1;

  arb_state_e        state_q, state_d;
  logic [GW-1:0]     gnt_q, gnt_d, last_q, last_d, pick;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   elig;
  logic              found, bad_opc;
  logic [2:0]        pick_opc;
  int                rr_idx;

  logic              tag_full, tag_empty, tag_push, tag_pop;
  logic [GW-1:0]     tag_head;

  logic              rget_q, rget_d, dcyc_q, dcyc_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [RET_W-1:0]  rsp_data_q, rsp_data_d;
  logic              err_q, err_d;

  // An SCR is held back while the tag queue cannot record it.
  always_comb begin
    elig   = '0;
    found  = 1'b0;
    pick   = '0;
    rr_idx = 0;
    for (int i = 0; i < NREQ; i++)
      elig[i] = req_valid[i] && !((req_cmd[CMD_W*i+OPC_HI -: 3] == SCR) && tag_full);
    for (int k = 1; k <= NREQ; k++) begin
      rr_idx = (int'(last_q) + k) % NREQ;
      if (!found && elig[rr_idx]) begin
        found = 1'b1;
        pick  = GW'(rr_idx);
      end
    end
    pick_opc = req_cmd[CMD_W*int'(pick)+OPC_HI -: 3];
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    last_d        = last_q;
    cmd_d         = cmd_q;
    cnt_d         = cnt_q;
    req_ready     = '0;
    req_wdata_get = '0;
    DATA_put      = 1'b0;
    DATA_data_in  = '0;
    CMD_put       = 1'b0;
    tag_push      = 1'b0;
    bad_opc       = 1'b0;
    if (!reset) begin
      unique case (state_q)
        IDLE: if (found) begin
          req_ready[pick] = 1'b1;
          gnt_d           = pick;
          last_d          = pick;
          cmd_d           = req_cmd[CMD_W*int'(pick) +: CMD_W];
          cnt_d           = '0;
          if (pick_opc == SCW)      state_d = WDATA;
          else if (pick_opc == SCR) state_d = PUSH;
          else                      bad_opc = 1'b1;
        end
        WDATA: if (!DATA_full) begin
          DATA_put              = 1'b1;
          DATA_data_in          = req_wdata[WD_W*int'(gnt_q) +: WD_W];
          req_wdata_get[gnt_q]  = 1'b1;
          cnt_d                 = cnt_q + 1'b1;
          if (cnt_q == CW'(BL-1)) state_d = PUSH;
        end
        PUSH: if (!CMD_full) begin
          CMD_put  = 1'b1;
          tag_push = (cmd_q[OPC_HI:OPC_LO] == SCR);
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Return path: one pop in flight; the data cycle follows RETURN_get.
  always_comb begin
    rget_d      = !RETURN_empty && !rget_q;
    dcyc_d      = rget_q;
    tag_pop     = dcyc_q && !tag_empty;
    rsp_valid_d = '0;
    if (tag_pop) rsp_valid_d[tag_head] = 1'b1;
    rsp_data_d  = tag_pop ? RETURN_data_out : rsp_data_q;
    err_d       = bad_opc || (dcyc_q && tag_empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      last_q      <= GW'(NREQ-1);
      cmd_q       <= '0;
      cnt_q       <= '0;
      rget_q      <= 1'b0;
      dcyc_q      <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      rget_q      <= rget_d;
      dcyc_q      <= dcyc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  ddr3_tag_fifo #(.W(GW), .DEPTH(TAG_DEPTH)) u_tags (
    .clk   (clk),
    .reset (reset),
    .push  (tag_push),
    .din   (gnt_q),
    .pop   (tag_pop),
    .full  (tag_full),
    .empty (tag_empty),
    .head  (tag_head)
  );

  assign CMD_data_in = cmd_q;
  assign RETURN_get  = rget_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign err         = err_q;
endmodule

// File: tb/tb_ddr3_cmd_arbiter.sv
// Scoreboard bench for ddr3_cmd_arbiter: tests queue expected grants/pushes/
// responses, a negedge monitor pops and compares whatever the DUT presents.
module tb_ddr3_cmd_arbiter;
  import ddr3_arb_pkg::*;
  localparam int NREQ = 4, BL = 8, TAG_DEPTH = 8;

  logic              clk = 1'b0, reset = 1'b1;
  logic [NREQ-1:0]   req_valid = '0, req_ready, req_wdata_get, rsp_valid;
  logic [NREQ*34-1:0] req_cmd = '0;
  logic [NREQ*16-1:0] req_wdata = '0;
  logic              CMD_full = 1'b0, CMD_put, DATA_full = 1'b0, DATA_put;
  logic              RETURN_empty = 1'b1, RETURN_get, err;
  logic [33:0]       CMD_data_in;
  logic [15:0]       DATA_data_in;
  logic [41:0]       RETURN_data_out = '0, rsp_data;

  always #5 clk = ~clk;

  ddr3_cmd_arbiter #(.NREQ(NREQ), .BL(BL), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_cmd(req_cmd),
    .req_ready(req_ready), .req_wdata(req_wdata), .req_wdata_get(req_wdata_get),
    .CMD_full(CMD_full), .CMD_put(CMD_put), .CMD_data_in(CMD_data_in),
    .DATA_full(DATA_full), .DATA_put(DATA_put), .DATA_data_in(DATA_data_in),
    .RETURN_empty(RETURN_empty), .RETURN_get(RETURN_get), .RETURN_data_out(RETURN_data_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err(err)
  );

  int n_tests = 0, n_fail = 0, cyc = 0;
  int rem[NREQ], wptr[NREQ], wget_cnt[NREQ];
  logic [33:0] cmd_r[NREQ];
  logic [15:0] base[NREQ];
  logic [NREQ-1:0] acc_f = '0, get_f = '0;
  logic rget_f = 1'b0;
  logic [41:0] ret_q[$];
  int exp_gnt[$], exp_rsp_idx[$], cmd_cyc[$], dput_cyc[$];
  logic [33:0] exp_cmd[$];
  logic [15:0] exp_data[$];
  logic [41:0] exp_rsp_data[$];
  int dput_cnt = 0, err_cnt = 0, rget_cnt = 0, cmd_dput = 0, mon_g, b;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [63:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected output %0h", nm, act);
  endtask

  function automatic logic [33:0] mk(input logic [2:0] opc, input logic [25:0] a);
    return {opc, a, 5'b0};
  endfunction

  function automatic int pending();
    return exp_gnt.size() + exp_cmd.size() + exp_data.size() + exp_rsp_idx.size();
  endfunction

  // Monitor: sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    acc_f  = req_ready;
    get_f  = req_wdata_get;
    rget_f = RETURN_get;
    if (req_ready != '0) begin
      mon_g = -1;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) mon_g = (mon_g == -1) ? i : 99;
      if (exp_gnt.size() == 0) unexpected("grant", 64'(mon_g));
      else chk("grant", 64'(mon_g), 64'(exp_gnt.pop_front()));
    end
    for (int i = 0; i < NREQ; i++) if (req_wdata_get[i]) wget_cnt[i]++;
    if (CMD_put) begin
      cmd_cyc.push_back(cyc);
      cmd_dput = dput_cnt;
      if (exp_cmd.size() == 0) unexpected("cmd_put", 64'(CMD_data_in));
      else chk("cmd_data", 64'(CMD_data_in), 64'(exp_cmd.pop_front()));
    end
    if (DATA_put) begin
      dput_cnt++;
      dput_cyc.push_back(cyc);
      if (exp_data.size() == 0) unexpected("data_put", 64'(DATA_data_in));
      else chk("data_word", 64'(DATA_data_in), 64'(exp_data.pop_front()));
    end
    if (rsp_valid != '0) begin
      mon_g = -1;
      for (int i = 0; i < NREQ; i++) if (rsp_valid[i]) mon_g = (mon_g == -1) ? i : 99;
      if (exp_rsp_idx.size() == 0) unexpected("rsp_valid", 64'(rsp_valid));
      else begin
        chk("rsp_idx", 64'(mon_g), 64'(exp_rsp_idx.pop_front()));
        chk("rsp_data", 64'(rsp_data), 64'(exp_rsp_data.pop_front()));
      end
    end
    if (err) err_cnt++;
    if (RETURN_get) rget_cnt++;
  end

  // Requester and RETURN FIFO models, updated just after each rising edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_f[i] && rem[i] > 0) rem[i]--;
      if (get_f[i]) wptr[i]++;
    end
    if (rget_f && ret_q.size() > 0) RETURN_data_out = ret_q.pop_front();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]         = rem[i] > 0;
      req_cmd[34*i +: 34]  = cmd_r[i];
      req_wdata[16*i +: 16] = base[i] + 16'(wptr[i]);
    end
    RETURN_empty = (ret_q.size() == 0);
  end

  task automatic chk_zero(input string nm);
    chk({nm, "_req_ready"}, 64'(req_ready), 0);
    chk({nm, "_wdata_get"}, 64'(req_wdata_get), 0);
    chk({nm, "_cmd_put"}, 64'(CMD_put), 0);
    chk({nm, "_data_put"}, 64'(DATA_put), 0);
    chk({nm, "_return_get"}, 64'(RETURN_get), 0);
    chk({nm, "_rsp_valid"}, 64'(rsp_valid), 0);
    chk({nm, "_err"}, 64'(err), 0);
    chk({nm, "_cmd_data"}, 64'(CMD_data_in), 0);
    chk({nm, "_data_in"}, 64'(DATA_data_in), 0);
    chk({nm, "_rsp_data"}, 64'(rsp_data), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2 reset = 1'b1;
    for (int i = 0; i < NREQ; i++) begin rem[i] = 0; wptr[i] = 0; wget_cnt[i] = 0; end
    ret_q.delete();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic drain(input string nm, input int budget);
    int k = 0;
    while (k < budget && pending() != 0) begin @(posedge clk); k++; end
    chk({nm, "_drain"}, 64'(pending()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 0; wptr[i] = 0; wget_cnt[i] = 0; cmd_r[i] = '0; base[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk) chk_zero("rst");
    @(posedge clk); #2 reset = 1'b0;

    // Round robin, all four hold SCR: 0,1,2,3,0 with CMD_put every 2 cycles
    cmd_cyc.delete();
    for (int i = 0; i < NREQ; i++) cmd_r[i] = mk(SCR, 26'(16'h100 + i));
    rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
    foreach (exp_gnt[i]) exp_gnt.delete();
    exp_gnt = '{0, 1, 2, 3, 0};
    exp_cmd = '{mk(SCR, 26'h100), mk(SCR, 26'h101), mk(SCR, 26'h102), mk(SCR, 26'h103), mk(SCR, 26'h100)};
    drain("rr", 100);
    for (int k = 0; k < 4; k++) chk("rr_spacing", 64'(cmd_cyc[k+1] - cmd_cyc[k]), 2);

    // SCW from requester 2 with a 3-cycle DATA_full stall mid-burst
    do_reset();
    dput_cnt = 0; dput_cyc.delete();
    cmd_r[2] = mk(SCW, 26'h222); base[2] = 16'h1000; rem[2] = 1;
    exp_gnt.push_back(2);
    for (int k = 0; k < BL; k++) exp_data.push_back(16'h1000 + 16'(k));
    exp_cmd.push_back(mk(SCW, 26'h222));
    b = 0;
    while (dput_cnt < 3 && b < 100) begin @(posedge clk); b++; end
    #2 DATA_full = 1'b1;
    repeat (3) @(posedge clk);
    #2 DATA_full = 1'b0;
    drain("scw", 100);
    chk("scw_wget", 64'(wget_cnt[2]), 8);
    chk("scw_cmd_after_data", 64'(cmd_dput), 8);
    chk("scw_stall_span", 64'(dput_cyc[7] - dput_cyc[0]), 10);

    // Return routing: SCRs from 1,3,1 then three returns
    do_reset();
    cmd_r[1] = mk(SCR, 26'h11); cmd_r[3] = mk(SCR, 26'h33);
    rem[1] = 2; rem[3] = 1;
    exp_gnt = '{1, 3, 1};
    exp_cmd = '{mk(SCR, 26'h11), mk(SCR, 26'h33), mk(SCR, 26'h11)};
    drain("route_cmd", 100);
    @(posedge clk);
    ret_q.push_back({26'h11, 16'hAAAA});
    ret_q.push_back({26'h33, 16'hBBBB});
    ret_q.push_back({26'h11, 16'hCCCC});
    exp_rsp_idx = '{1, 3, 1};
    exp_rsp_data = '{{26'h11, 16'hAAAA}, {26'h33, 16'hBBBB}, {26'h11, 16'hCCCC}};
    drain("route_rsp", 100);

    // Tag queue full: 8 SCRs outstanding, SCR from 1 held while SCW from 2 wins
    do_reset();
    cmd_r[3] = mk(SCR, 26'h300); rem[3] = 8;
    for (int k = 0; k < 8; k++) begin exp_gnt.push_back(3); exp_cmd.push_back(mk(SCR, 26'h300)); end
    drain("tag_fill", 200);
    cmd_r[1] = mk(SCR, 26'h101); rem[1] = 1;
    cmd_r[2] = mk(SCW, 26'h202); base[2] = 16'h5000; wptr[2] = 0; rem[2] = 1;
    exp_gnt.push_back(2); exp_gnt.push_back(1);
    for (int k = 0; k < BL; k++) exp_data.push_back(16'h5000 + 16'(k));
    exp_cmd.push_back(mk(SCW, 26'h202)); exp_cmd.push_back(mk(SCR, 26'h101));
    b = 0;
    while (exp_cmd.size() > 1 && b < 100) begin @(posedge clk); b++; end
    repeat (5) @(posedge clk);
    chk("tagfull_hold", 64'(exp_gnt.size()), 1);
    ret_q.push_back({26'h300, 16'h1234});
    exp_rsp_idx.push_back(3); exp_rsp_data.push_back({26'h300, 16'h1234});
    drain("tag_release", 100);

    // Illegal opcode then an orphan return: two err pulses, no push, no response
    do_reset();
    err_cnt = 0; rget_cnt = 0;
    cmd_r[0] = mk(3'b111, 26'h5); rem[0] = 1;
    exp_gnt.push_back(0);
    drain("illegal", 50);
    repeat (3) @(posedge clk);
    ret_q.push_back({26'h3ff, 16'hDEAD});
    b = 0;
    while (ret_q.size() != 0 && b < 50) begin @(posedge clk); b++; end
    repeat (4) @(posedge clk);
    chk("err_count", 64'(err_cnt), 2);
    chk("orphan_get", 64'(rget_cnt), 1);
    chk("orphan_popped", 64'(ret_q.size()), 0);

    // Reset during WDATA at word 4: burst abandoned, requester 0 wins afterwards
    do_reset();
    dput_cnt = 0;
    cmd_r[1] = mk(SCW, 26'h77); base[1] = 16'h7000; rem[1] = 1;
    exp_gnt.push_back(1);
    for (int k = 0; k < 4; k++) exp_data.push_back(16'h7000 + 16'(k));
    b = 0;
    while (dput_cnt < 4 && b < 100) begin @(posedge clk); b++; end
    chk("midrst_words", 64'(dput_cnt), 4);
    #2 reset = 1'b1;
    rem[1] = 0;
    cmd_r[0] = mk(SCR, 26'h80); cmd_r[2] = mk(SCR, 26'h82);
    rem[0] = 1; rem[2] = 1;
    @(posedge clk);
    @(negedge clk) chk_zero("midrst");
    @(posedge clk); #2 reset = 1'b0;
    exp_gnt.push_back(0); exp_gnt.push_back(2);
    exp_cmd.push_back(mk(SCR, 26'h80)); exp_cmd.push_back(mk(SCR, 26'h82));
    drain("post_rst", 100);
    repeat (5) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
